pe_au_sequencer: RTL and testbench
==================================

Name: pe_au_sequencer

Overview:
- Control sequencer for one PE_AU DSP48E2 multiply-accumulate slice in the AMNS Montgomery multiplier datapath.
- On a start command, it requests N operand pairs from the upstream feeder and pulses the CREG clock enable for the accumulator seed.
- It drives a per-term OPMODE that is pipeline-aligned to the DSP's internal ABREG/MREG/OPMODEREG/PREG stages.
- It flags the cycle in which RES_dout holds the final accumulated sum, then holds P until the next command.

Parameters:
- ABREG, 1, A/B register depth configured in the paired PE_AU. ABREG+MREG must be at least 1.
- MREG, 1, M register depth configured in the paired PE_AU.
- N_MAX, 5, maximum terms per accumulation.
- CNT_W, 3, width of the term count/index; 2^CNT_W must exceed N_MAX.

Ports:
- clock_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- start_i  in  1  command request; accepted only when ready_o=1.
- mode_i  in  2  seed select, sampled at accept: 00 C, 01 zero, 10 PCIN, 11 P>>17.
- n_terms_i  in  CNT_W  number of products to accumulate, sampled at accept.
- ready_o  out  1  idle and able to accept a command.
- busy_o  out  1  equals NOT ready_o.
- operand_valid_o  out  1  upstream must present A_din/B_din this cycle.
- term_idx_o  out  CNT_W  index of the operand requested this cycle.
- CREG_en_o  out  1  connects to PE_AU CREG_en_i.
- OPMODE_o  out  9  connects to PE_AU OPMODE_i.
- res_valid_o  out  1  one-cycle pulse; PE_AU RES_dout holds the final sum.

Behaviour:
- Reset values (synchronous, reset_n_i=0 at a clock edge):
  - FSM=IDLE, ready_o=1, operand_valid_o=0, term_idx_o=0, CREG_en_o=0, res_valid_o=0.
  - OPMODE_o=9'h000, which forces P=0.
  - All alignment flags cleared.
  - Reset mid-operation aborts the command immediately; no res_valid_o is produced.
- OPMODE encodings, as {W,Z,Y,X}:
  - SEED_C 9'h185 (C+M)
  - SEED_ZERO 9'h005 (M)
  - SEED_PCIN 9'h015 (PCIN+M)
  - SEED_SHIFT 9'h065 ((P>>17)+M)
  - MAC 9'h025 (P+M)
  - HOLD 9'h020 (P=P)
- FSM IDLE:
  - ready_o=1.
  - Accept when start_i=1 and n_terms_i!=0: latch mode_i and n_terms_i, then go to ISSUE.
  - n_terms_i=0: start is ignored and the FSM stays in IDLE.
  - n_terms_i>N_MAX: the count saturates to N_MAX.
  - In the accept cycle, CREG_en_o=1 if and only if mode_i=00. C_din must be valid in that cycle; CREG holds it afterwards.
- FSM ISSUE:
  - operand_valid_o=1 for exactly n consecutive cycles, with term_idx_o=0..n-1.
  - Go to DRAIN after term n-1.
  - Upstream has no backpressure; operands are consumed every cycle.
- FSM DRAIN:
  - Lasts L=ABREG+MREG+1 cycles.
  - res_valid_o=1 in the last DRAIN cycle, which is exactly L cycles after the last operand_valid_o cycle.
  - Return to IDLE in the next cycle.
  - A new start cannot be accepted before IDLE, so there is no command overlap.
- OPMODE alignment:
  - A valid/first flag pair is delayed by D=ABREG+MREG-1 cycles (D=0 means combinational) from operand_valid_o.
  - OPMODE_o is registered, so it is driven in cycle (operand cycle + D). The internal OPMODEREG then meets the M register output.
  - Delayed term with first=1: OPMODE_o is the latched seed code.
  - Delayed term with first=0: OPMODE_o is MAC.
  - No delayed term: OPMODE_o is HOLD, so the result stays on RES_dout after res_valid_o until the next command.
- n=1 case: only the seed opcode is issued.
- SEED_SHIFT and SEED_PCIN rely on the previous P or on a cascaded neighbour. The block does not check that dependency.

Test Plan:
- Timing, ABREG=MREG=1, mode=00, n=3, start at cycle 0:
  - CREG_en_o=1 at cycle 0.
  - operand_valid_o at cycles 1–3, term_idx_o=0,1,2.
  - OPMODE_o = 185,025,025 at cycles 2–4, then 020.
  - res_valid_o at cycle 6; ready_o at cycle 7.
  - With A=2,3,4, B=5,6,7, C=10: RES_dout = 10+10+18+28 = 66 at cycle 6 and held afterwards.
- Seed codes: mode=01 (n=2) → first OPMODE_o 005, CREG_en_o stays 0. mode=10 → 015. mode=11 → 065. Each followed by MAC then HOLD.
- Count edge cases:
  - n_terms_i=0 with start → ignored; ready_o stays 1 and no outputs toggle.
  - n_terms_i=7 with N_MAX=5 → exactly 5 operand_valid_o cycles.
- Handshake: start held high continuously → commands accepted only in IDLE cycles, with back-to-back spacing of n+L+1 cycles. start while busy has no effect.
- Reset: reset_n_i=0 during the 2nd ISSUE cycle → next cycle IDLE, OPMODE_o=000, no res_valid_o. A subsequent command then runs normally.
- Parameter sweep: ABREG=0,MREG=1 (D=0, L=2) and ABREG=1,MREG=0 → seed OPMODE_o appears in the same cycle as term 0. res_valid_o arrives 2 cycles after the last operand, checked against a DSP48E2 model.

Source files
------------

// File: rtl/pe_au_sequencer.sv
// pe_au_sequencer: control sequencer for one PE_AU DSP48E2 multiply-accumulate slice.
// Accepts a command (seed mode + term count), requests n operand pairs from the
// upstream feeder on consecutive cycles, and pulses CREG_en when a command is accepted
// with the C seed. It drives per-term OPMODE codes that line up with the DSP's
// ABREG/MREG/OPMODEREG/PREG stages, and flags the cycle in which RES_dout holds the
// final sum. Afterwards P is held until the next command.
//
// Ports:
//   clock_i          clock
//   reset_n_i        synchronous active-low reset
//   start_i          command request, accepted only while ready_o=1
//   mode_i[1:0]      seed select: 00 C, 01 zero, 10 PCIN, 11 P>>17
//   n_terms_i        number of products to accumulate (0 ignored, >N_MAX saturates)
//   ready_o/busy_o   idle / not idle
//   operand_valid_o  upstream presents A_din/B_din this cycle
//   term_idx_o       index of the operand requested this cycle
//   CREG_en_o        to PE_AU CREG_en_i (combinational, accept cycle only)
//   OPMODE_o[8:0]    to PE_AU OPMODE_i
//   res_valid_o      one-cycle pulse: RES_dout holds the final sum
module pe_au_sequencer #(
    parameter int unsigned ABREG = 1,
    parameter int unsigned MREG  = 1,
    parameter int unsigned N_MAX = 5,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] n_terms_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             operand_valid_o,
    output logic [CNT_W-1:0] term_idx_o,
    output logic             CREG_en_o,
    output logic [8:0]       OPMODE_o,
    output logic             res_valid_o
);

    // ABREG+MREG must be at least 1; DLY aligns OPMODE_o with the M register output.
    localparam int unsigned DLY = (ABREG + MREG > 0) ? (ABREG + MREG - 1) : 0;
    localparam int unsigned LAT = ABREG + MREG + 1;
    localparam int unsigned DW  = (LAT > 2) ? $clog2(LAT) : 1;

    localparam logic [8:0] OP_SEED_C     = 9'h185;
    localparam logic [8:0] OP_SEED_ZERO  = 9'h005;
    localparam logic [8:0] OP_SEED_PCIN  = 9'h015;
    localparam logic [8:0] OP_SEED_SHIFT = 9'h065;
    localparam logic [8:0] OP_MAC        = 9'h025;
    localparam logic [8:0] OP_HOLD       = 9'h020;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] idx_q, idx_nxt;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [DW-1:0]    dcnt_q, dcnt_nxt;
    logic             accept;
    logic             valid_nxt;
    logic             first_nxt;
    logic             term_v;
    logic             term_f;
    logic [1:0]       seed_mode;
    logic [8:0]       seed_code;
    logic [8:0]       opmode_nxt;

    // State and command registers
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            mode_q  <= 2'b00;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            n_q     <= n_nxt;
            mode_q  <= mode_nxt;
            dcnt_q  <= dcnt_nxt;
        end
    end

    // Next-state logic: IDLE -> ISSUE (n terms) -> DRAIN (LAT cycles) -> IDLE
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        n_nxt     = n_q;
        mode_nxt  = mode_q;
        dcnt_nxt  = dcnt_q;
        accept    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (reset_n_i && start_i && (n_terms_i != '0)) begin
                    accept    = 1'b1;
                    n_nxt     = (n_terms_i > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : n_terms_i;
                    mode_nxt  = mode_i;
                    idx_nxt   = '0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (idx_q == n_q - CNT_W'(1)) begin
                    idx_nxt   = '0;
                    dcnt_nxt  = '0;
                    state_nxt = ST_DRAIN;
                end else begin
                    idx_nxt = idx_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DW'(LAT - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    dcnt_nxt = dcnt_q + DW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        valid_nxt = (state_nxt == ST_ISSUE);
        first_nxt = accept;
    end

    // Delay the next-cycle valid/first pair by DLY so the registered OPMODE_o
    // lands in OPMODEREG together with the product leaving the M register.
    generate
        if (DLY == 0) begin : g_nodly
            assign term_v = valid_nxt;
            assign term_f = first_nxt;
        end else begin : g_dly
            logic [DLY-1:0] v_sr;
            logic [DLY-1:0] f_sr;
            always_ff @(posedge clock_i) begin
                if (!reset_n_i) begin
                    v_sr <= '0;
                    f_sr <= '0;
                end else begin
                    v_sr <= DLY'({v_sr, valid_nxt});
                    f_sr <= DLY'({f_sr, first_nxt});
                end
            end
            assign term_v = v_sr[DLY-1];
            assign term_f = f_sr[DLY-1];
        end
    endgenerate

    // Seed mode comes straight from the command when the seed opcode is issued in the
    // accept cycle's successor (DLY=0), otherwise from the latched copy.
    always_comb begin
        seed_mode = (DLY == 0) ? mode_i : mode_q;
        unique case (seed_mode)
            2'b00:   seed_code = OP_SEED_C;
            2'b01:   seed_code = OP_SEED_ZERO;
            2'b10:   seed_code = OP_SEED_PCIN;
            default: seed_code = OP_SEED_SHIFT;
        endcase
        opmode_nxt = OP_HOLD;
        if (term_v) begin
            opmode_nxt = term_f ? seed_code : OP_MAC;
        end
    end

    // OPMODE register; reset value 000 forces P=0 in the slice
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            OPMODE_o <= 9'h000;
        end else begin
            OPMODE_o <= opmode_nxt;
        end
    end

    // Status outputs decoded from the state/counter flops
    assign ready_o         = (state_q == ST_IDLE);
    assign busy_o          = ~ready_o;
    assign operand_valid_o = (state_q == ST_ISSUE);
    assign term_idx_o      = idx_q;
    assign res_valid_o     = (state_q == ST_DRAIN) && (dcnt_q == DW'(LAT - 1));
    // C_din is valid in the accept cycle, so the enable cannot wait a cycle
    assign CREG_en_o       = accept && (mode_i == 2'b00);

endmodule

// File: tb/tb_pe_au_sequencer.sv
// Bench for pe_au_sequencer: three instances (ABREG/MREG = 1/1, 0/1, 1/0) share one
// stimulus; each drives a small behavioural DSP48E2 slice model whose P is checked
// against plain arithmetic sums.
`timescale 1ns/1ps
module tb_pe_au_sequencer;

    localparam int NI = 3;
    localparam int unsigned AB_CFG [NI] = '{1, 0, 1};
    localparam int unsigned M_CFG  [NI] = '{1, 1, 0};
    localparam int N_MAX = 5;
    localparam longint PCIN = 12345;
    localparam logic [8:0] OP_MAC  = 9'h025;
    localparam logic [8:0] OP_HOLD = 9'h020;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [2:0] n_in  = 3'd0;
    longint     c_din = 0;
    longint     a_tab [8];
    longint     b_tab [8];

    logic       rdy  [NI];
    logic       bsy  [NI];
    logic       ov   [NI];
    logic [2:0] idx  [NI];
    logic       creg [NI];
    logic [8:0] opm  [NI];
    logic       res  [NI];
    longint     p_arr [NI];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DSP48E2 ALU subset: W (0 or C) + Z (0, PCIN, P, P>>17) + X/Y (M)
    function automatic longint dsp_alu(input logic [8:0] op, input longint m,
                                       input longint c, input longint p);
        longint w, z, xy;
        w = (op[8:7] == 2'b11) ? c : 0;
        case (op[6:4])
            3'b001:  z = PCIN;
            3'b010:  z = p;
            3'b110:  z = p >> 17;
            default: z = 0;
        endcase
        xy = (op[3:0] == 4'b0101) ? m : 0;
        return (w + z + xy) & 64'h0000_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [8:0] seed_op(input logic [1:0] md);
        case (md)
            2'b00:   return 9'h185;
            2'b01:   return 9'h005;
            2'b10:   return 9'h015;
            default: return 9'h065;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned DP = AB_CFG[g] + M_CFG[g];
        longint     m_sr [DP];
        longint     a_in;
        longint     b_in;
        longint     c_r   = 0;
        longint     p_r   = 0;
        logic [8:0] opm_r = 9'h000;

        pe_au_sequencer #(
            .ABREG (AB_CFG[g]),
            .MREG  (M_CFG[g]),
            .N_MAX (N_MAX),
            .CNT_W (3)
        ) u_dut (
            .clock_i         (clk),
            .reset_n_i       (rst_n),
            .start_i         (start),
            .mode_i          (mode),
            .n_terms_i       (n_in),
            .ready_o         (rdy[g]),
            .busy_o          (bsy[g]),
            .operand_valid_o (ov[g]),
            .term_idx_o      (idx[g]),
            .CREG_en_o       (creg[g]),
            .OPMODE_o        (opm[g]),
            .res_valid_o     (res[g])
        );

        // Upstream feeder: presents the requested operand pair
        always_comb begin
            a_in = ov[g] ? a_tab[idx[g]] : 0;
            b_in = ov[g] ? b_tab[idx[g]] : 0;
        end

        // Slice pipeline: product delayed ABREG+MREG stages, OPMODEREG, CREG, PREG
        always @(posedge clk) begin
            m_sr[0] <= a_in * b_in;
            for (int k = 1; k < int'(DP); k++) m_sr[k] <= m_sr[k-1];
            opm_r <= opm[g];
            if (creg[g]) c_r <= c_din;
            p_r <= dsp_alu(opm_r, m_sr[DP-1], c_r, p_r);
        end

        assign p_arr[g] = p_r;
    end

    task automatic chk(input string nm, input int inst, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    // Model: command timeline per instance, derived from accept cycle, count and latency
    int         acc  [NI];
    int         nacc [NI];
    int         bend [NI] = '{0, 0, 0};
    logic [1:0] macc [NI];
    bit         aok  [NI] = '{0, 0, 0};
    longint     esum [NI];
    longint     lastp [NI] = '{0, 0, 0};
    bit         rst_last = 1'b1;

    always @(negedge clk) begin
        bit         idle, ev, er, ea;
        int         rel, k, dl, ll, ns;
        logic [8:0] eop;
        longint     s;
        if (check_en) begin
            for (int i = 0; i < NI; i++) begin
                dl   = int'(AB_CFG[i] + M_CFG[i]) - 1;
                ll   = int'(AB_CFG[i] + M_CFG[i]) + 1;
                idle = (cyc >= bend[i]);
                rel  = cyc - acc[i];
                ev   = aok[i] && !idle && rel >= 1 && rel <= nacc[i];
                chk("ready", i, rdy[i], idle);
                chk("busy", i, bsy[i], !idle);
                chk("operand_valid", i, ov[i], ev);
                if (ev) chk("term_idx", i, idx[i], rel - 1);
                k = rel - 1 - dl;
                if (rst_last) eop = 9'h000;
                else if (aok[i] && k >= 0 && k < nacc[i]) eop = (k == 0) ? seed_op(macc[i]) : OP_MAC;
                else eop = OP_HOLD;
                chk("opmode", i, opm[i], eop);
                er = aok[i] && rel == nacc[i] + ll;
                chk("res_valid", i, res[i], er);
                if (aok[i] && (rel == nacc[i] + ll || rel == nacc[i] + ll + 1))
                    chk("res_dout", i, p_arr[i], esum[i]);
                ea = idle && start && n_in != 3'd0 && rst_n;
                chk("creg_en", i, creg[i], ea && mode == 2'b00);
                if (er) lastp[i] = esum[i];
                if (!rst_n) begin
                    bend[i]  = 0;
                    aok[i]   = 1'b0;
                    lastp[i] = 0;
                end else if (ea) begin
                    ns = (int'(n_in) > N_MAX) ? N_MAX : int'(n_in);
                    case (mode)
                        2'b00:   s = c_din;
                        2'b01:   s = 0;
                        2'b10:   s = PCIN;
                        default: s = lastp[i] >> 17;
                    endcase
                    for (int t = 0; t < ns; t++) s += a_tab[t] * b_tab[t];
                    acc[i]  = cyc;
                    nacc[i] = ns;
                    macc[i] = mode;
                    bend[i] = cyc + ns + ll + 1;
                    aok[i]  = 1'b1;
                    esum[i] = s;
                end
            end
            rst_last = !rst_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!(rdy[0] && rdy[1] && rdy[2])) begin
            if (w == 60) begin
                checks++;
                errors++;
                $display("FAIL wait_idle timeout cycle %0d got busy expected idle", cyc);
                return;
            end
            step();
            w++;
        end
        step();
    endtask

    // Two-term command with pinned seed/MAC/HOLD sequence on the 1/1 instance
    task automatic run2(input logic [1:0] md, input logic [8:0] seed_exp, input bit creg_exp);
        mode = md; n_in = 3'd2; start = 1'b1;
        @(negedge clk); chk("pin_creg", 0, creg[0], creg_exp);
        step(); start = 1'b0;
        @(negedge clk); step();
        @(negedge clk); chk("pin_seed", 0, opm[0], seed_exp);
        step();
        @(negedge clk); chk("pin_mac", 0, opm[0], OP_MAC);
        step();
        @(negedge clk); chk("pin_hold", 0, opm[0], OP_HOLD);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle %0d got running expected finished", cyc);
        $fatal(1);
    end

    initial begin
        int cnt, first, second;
        for (int k = 0; k < 8; k++) begin a_tab[k] = 0; b_tab[k] = 0; end
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 0, rdy[0], 1);
        chk("rst_opmode", 0, opm[0], 0);
        chk("rst_valid", 0, ov[0], 0);
        step(); rst_n = 1'b1;
        step(); step();

        // Main timing case: C=10, A=2,3,4, B=5,6,7, n=3 -> 66
        a_tab[0] = 2; a_tab[1] = 3; a_tab[2] = 4;
        b_tab[0] = 5; b_tab[1] = 6; b_tab[2] = 7;
        c_din = 10; mode = 2'b00; n_in = 3'd3; start = 1'b1;
        for (int t = 0; t <= 7; t++) begin
            @(negedge clk);
            case (t)
                0: chk("pin_creg_c", 0, creg[0], 1);
                1: begin chk("pin_valid0", 0, ov[0], 1); chk("pin_seed_d0", 1, opm[1], 9'h185); end
                2: chk("pin_seed_c", 0, opm[0], 9'h185);
                3: chk("pin_mac1", 0, opm[0], OP_MAC);
                4: chk("pin_mac2", 0, opm[0], OP_MAC);
                5: begin chk("pin_hold", 0, opm[0], OP_HOLD);
                         chk("pin_res_d0", 1, res[1], 1); chk("pin_sum_d0", 1, p_arr[1], 66); end
                6: begin chk("pin_res", 0, res[0], 1); chk("pin_sum", 0, p_arr[0], 66); end
                default: begin chk("pin_ready", 0, rdy[0], 1); chk("pin_held", 0, p_arr[0], 66); end
            endcase
            step();
            if (t == 0) start = 1'b0;
        end
        wait_idle();

        // Seed codes
        run2(2'b01, 9'h005, 1'b0);
        a_tab[0] = 1000; a_tab[1] = 1000; b_tab[0] = 1000; b_tab[1] = 1000;
        run2(2'b10, 9'h015, 1'b0);
        a_tab[0] = 2; a_tab[1] = 3; b_tab[0] = 5; b_tab[1] = 6;
        run2(2'b11, 9'h065, 1'b0);

        // Zero count is ignored
        mode = 2'b00; n_in = 3'd0; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("zero_ready", 0, rdy[0], 1);
            chk("zero_creg", 0, creg[0], 0);
            step();
        end
        start = 1'b0;

        // Count saturates at N_MAX
        for (int k = 0; k < 8; k++) begin a_tab[k] = k + 1; b_tab[k] = 1; end
        mode = 2'b01; n_in = 3'd7; start = 1'b1;
        cnt = 0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (ov[0]) cnt++;
            step();
            if (t == 0) start = 1'b0;
        end
        chk("sat_count", 0, cnt, 5);
        wait_idle();

        // Start held high: accepted only from IDLE, spacing n+L+1
        mode = 2'b00; n_in = 3'd2; c_din = 7; start = 1'b1;
        first = -1; second = -1;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (creg[0]) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            step();
        end
        start = 1'b0;
        chk("b2b_spacing", 0, second - first, 6);
        wait_idle();

        // Reset during the second ISSUE cycle aborts the command
        a_tab[0] = 2; a_tab[1] = 3; a_tab[2] = 4;
        b_tab[0] = 5; b_tab[1] = 6; b_tab[2] = 7;
        c_din = 10; mode = 2'b00; n_in = 3'd3; start = 1'b1;
        @(negedge clk); step(); start = 1'b0;
        @(negedge clk); step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", 0, ov[0], 1);
        chk("abort_idx", 0, idx[0], 1);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 0, rdy[0], 1);
        chk("abort_opmode", 0, opm[0], 0);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("abort_no_res", 0, res[0], 0);
            step();
        end

        // Normal command after the abort
        start = 1'b1;
        @(negedge clk); step(); start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("post_abort_sum", 0, p_arr[0], 66);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
